mem_store_ctrl: RTL and testbench
=================================

MEM_STORE_CTRL -- requirements
Module: mem_store_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum cycles to wait for ram_ack before aborting.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port str_req  in  1  store request from memory control (opcode is STR).
REQ-005 SHALL have port str_addr  in  32  byte address of the store.
REQ-006 SHALL have port str_data  in  32  store data from the register bank.
REQ-007 SHALL have port str_size  in  2  store size: 00 word, 01 halfword, 10 byte, 11 reserved.
REQ-008 SHALL have port str_busy  out  1  high when a store is in progress and requests are not accepted.
REQ-009 SHALL have port str_done  out  1  one-cycle pulse when a store completes.
REQ-010 SHALL have port str_err  out  1  one-cycle pulse on a misaligned, reserved-size or timed-out store.
REQ-011 SHALL have port ram_addr  out  32  word-aligned RAM address (bits [1:0] = 00).
REQ-012 SHALL have port ram_wdata  out  32  RAM write data.
REQ-013 SHALL have port ram_we  out  1  RAM write strobe, held until ram_ack.
REQ-014 SHALL have port ram_re  out  1  RAM read strobe, held until ram_ack.
REQ-015 SHALL have port ram_rdata  in  32  RAM read data, valid when ram_ack is high.
REQ-016 SHALL have port ram_ack  in  1  RAM completion acknowledge.

Function
REQ-017 SHALL implement the FSM states IDLE, RD, WR and FIN.
REQ-018 SHALL, in IDLE with str_req=1, capture addr/data/size and deassert str_busy only when back in IDLE.
REQ-019 SHALL, for an accepted word store, go IDLE->WR: ram_we=1 from the next cycle, ram_wdata=str_data, ram_addr={addr[31:2],2'b00}.
REQ-020 SHALL, for an accepted halfword or byte store, go IDLE->RD (ram_re=1), then on ram_ack go to WR and merge the data into ram_rdata.
REQ-021 SHALL use little-endian lane placement: byte lane = addr[1:0]; halfword occupies lanes {addr[1],0} and {addr[1],1}.
REQ-022 SHALL, in WR, go to FIN on ram_ack; FIN pulses str_done for one cycle and returns to IDLE.
REQ-023 SHALL give minimum word-store latency as: req captured at edge k, ram_we high during cycle k+1, ack in cycle k+1, str_done high in cycle k+2.
REQ-024 SHALL reject a word store with addr[1:0]!=0, a halfword store with addr[0]=1, or size 11: str_err pulses the cycle after capture, no RAM strobe is issued, and the FSM returns to IDLE.
REQ-025 SHALL count cycles in RD/WR while ram_ack=0 and reset the counter on each state entry; on reaching WAIT_MAX it drops the strobe, pulses str_err and returns to IDLE without pulsing str_done.
REQ-026 SHALL ignore str_req while busy (no queueing).
REQ-027 SHALL ignore ram_ack in IDLE and FIN.
REQ-028 SHALL never assert ram_we and ram_re simultaneously.

Reset
REQ-029 SHALL, on rst_n=0, immediately set state=IDLE and clear all outputs (str_busy, str_done, str_err, ram_we, ram_re, ram_addr, ram_wdata) and the wait counter to 0.
REQ-030 SHALL, on reset mid-store, abandon the store with no done or err pulse; the store is not resumed.

Configuration
REQ-031 SHALL use macro STR_SUBWORD_EN: when defined, halfword and byte stores use RD->WR read-modify-write.
REQ-032 SHALL, without STR_SUBWORD_EN, omit the RD state and merge logic and treat any str_size!=00 as an error (str_err pulse, no RAM access).

Structure
REQ-033 SHALL place the size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and the state encodings in the shared package mem_ctrl_pkg.
REQ-034 SHALL implement the lane merge (rdata, wdata, addr[1:0], size -> merged word) as the combinational sub-module store_lane_merge.

Verification
REQ-035 SHALL verify: word STR addr=0x100, data=0xDEADBEEF, ack same cycle -> ram_we one cycle, ram_addr=0x100, str_done at k+2.
REQ-036 SHALL verify: byte STR addr=0x103, data=0x000000AB, ram_rdata=0x11223344 -> ram_re then ram_we with ram_wdata=0xAB223344.
REQ-037 SHALL verify: halfword STR addr=0x201 -> str_err pulse, ram_we and ram_re never asserted.
REQ-038 SHALL verify: word STR with ram_ack held 0 -> strobe drops after 15 cycles, str_err pulses once, str_done stays 0.
REQ-039 SHALL verify: rst_n low while in WR -> ram_we falls without waiting for a clock edge, state=IDLE, no str_done; a second str_req while busy is ignored.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory store controller: store sizes, FSM states and
// the alignment rule for sub-word stores.
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRd   = 2'b01,
    StWr   = 2'b10,
    StFin  = 2'b11
  } str_state_e;

  // High when the store cannot be issued: misaligned for its size or reserved size.
  function automatic logic str_bad_align(input logic [1:0] lane, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_WORD: bad = (lane != 2'b00);
      SZ_HALF: bad = lane[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Little-endian lane merge: overlays the store data onto the word read back from RAM.
module store_lane_merge
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  output logic [31:0] merged
);

  always_comb begin
    merged = rdata;
    case (size)
      SZ_WORD: merged = wdata;
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/mem_store_ctrl.sv
// Store controller: word stores write directly; with STR_SUBWORD_EN defined, halfword
// and byte stores do a read-modify-write. RAM waits are bounded by WAIT_MAX cycles.
module mem_store_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        str_req,
  input  logic [31:0] str_addr,
  input  logic [31:0] str_data,
  input  logic [1:0]  str_size,
  output logic        str_busy,
  output logic        str_done,
  output logic        str_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  output logic        ram_re,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack
);

  localparam int unsigned CntW = $clog2(WAIT_MAX + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_MAX - 1);

  str_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           err_q, err_d;
  logic           reject;

`ifdef STR_SUBWORD_EN
  logic [31:0] data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] merged;

  store_lane_merge u_merge (
    .rdata  (ram_rdata),
    .wdata  (data_q),
    .lane   (lane_q),
    .size   (size_q),
    .merged (merged)
  );

  assign reject = str_bad_align(str_addr[1:0], str_size);
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign reject = (str_size != SZ_WORD) || (str_addr[1:0] != 2'b00);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
`ifdef STR_SUBWORD_EN
    data_d  = data_q;
    size_d  = size_q;
    lane_d  = lane_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (str_req) begin
          cnt_d = '0;
          if (reject) begin
            err_d = 1'b1;
          end else begin
            addr_d  = {str_addr[31:2], 2'b00};
            wdata_d = str_data;
`ifdef STR_SUBWORD_EN
            data_d  = str_data;
            size_d  = str_size;
            lane_d  = str_addr[1:0];
            state_d = (str_size == SZ_WORD) ? StWr : StRd;
`else
            state_d = StWr;
`endif
          end
        end
      end
      StRd: begin
`ifdef STR_SUBWORD_EN
        if (ram_ack) begin
          wdata_d = merged;
          cnt_d   = '0;
          state_d = StWr;
        end else if (cnt_q == CntLast) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`else
        state_d = StIdle;
`endif
      end
      StWr: begin
        if (ram_ack) begin
          cnt_d   = '0;
          state_d = StFin;
        end else if (cnt_q == CntLast) begin
          // Timeout: drop the strobe and report an error instead of done.
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef STR_SUBWORD_EN
      data_q  <= '0;
      size_q  <= SZ_WORD;
      lane_q  <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef STR_SUBWORD_EN
      data_q  <= data_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
`endif
    end
  end

  // Strobes decode straight from state so the async reset drops them immediately.
  assign ram_we    = (state_q == StWr);
  assign ram_re    = (state_q == StRd);
  assign str_busy  = (state_q != StIdle);
  assign str_done  = (state_q == StFin);
  assign str_err   = err_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Scoreboard bench for mem_store_ctrl: directed stores push expected RAM/handshake
// events; a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_store_ctrl;

  localparam int EvWe   = 0;
  localparam int EvRe   = 1;
  localparam int EvDone = 2;
  localparam int EvErr  = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        str_req = 1'b0;
  logic [31:0] str_addr = '0;
  logic [31:0] str_data = '0;
  logic [1:0]  str_size = 2'b00;
  logic        str_busy, str_done, str_err;
  logic [31:0] ram_addr, ram_wdata;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata = 32'h1122_3344;
  logic        ram_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  ev_t exp_q[$];
  int ack_delay = 0;
  int hold = 0;
  logic act = 1'b0;
  logic prev_kind = 1'b0;
  logic we_prev = 1'b0;
  logic re_prev = 1'b0;
  int monitor_on = 1;

  mem_store_ctrl #(.WAIT_MAX(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .str_req   (str_req),
    .str_addr  (str_addr),
    .str_data  (str_data),
    .str_size  (str_size),
    .str_busy  (str_busy),
    .str_done  (str_done),
    .str_err   (str_err),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .ram_ack   (ram_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind == EvWe) begin
        check("we_addr", ram_addr, e.addr);
        check("we_wdata", ram_wdata, e.data);
      end else if (kind == EvRe) begin
        check("re_addr", ram_addr, e.addr);
      end
    end
  endtask

  // RAM responder: acks ack_delay cycles after a strobe starts; negative never acks.
  always @(negedge clk) begin
    if (ram_we || ram_re) begin
      if (!act || (ram_we != prev_kind)) hold = 0;
      ram_ack = (ack_delay >= 0) && (hold == ack_delay);
      hold++;
      act = 1'b1;
      prev_kind = ram_we;
    end else begin
      act = 1'b0;
      ram_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (monitor_on != 0) begin
      if (ram_we && ram_re) check("we_re_overlap", 32'd1, 32'd0);
      if (ram_re && !re_prev) observe(EvRe);
      if (ram_we && !we_prev) observe(EvWe);
      if (str_done) observe(EvDone);
      if (str_err) observe(EvErr);
    end
    we_prev = ram_we;
    re_prev = ram_re;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    str_addr = a;
    str_data = d;
    str_size = sz;
    str_req  = 1'b1;
    @(posedge clk);
    #1 str_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (str_busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("wait_idle_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // Reset state, sampled while reset is still asserted.
    #12;
    check("rst_busy", 32'(str_busy), 32'd0);
    check("rst_done", 32'(str_done), 32'd0);
    check("rst_err", 32'(str_err), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_re", 32'(ram_re), 32'd0);
    check("rst_addr", ram_addr, 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word store, ack in the strobe cycle: we in k+1, done in k+2.
    ack_delay = 0;
    push(EvWe, 32'h100, 32'hDEAD_BEEF);
    push(EvDone, 32'h0, 32'h0);
    issue(32'h100, 32'hDEAD_BEEF, 2'b00);
    @(negedge clk);
    check("word_we_k1", 32'(ram_we), 32'd1);
    check("word_busy_k1", 32'(str_busy), 32'd1);
    @(negedge clk);
    check("word_done_k2", 32'(str_done), 32'd1);
    check("word_we_k2", 32'(ram_we), 32'd0);
    wait_idle();

    // Byte store into lane 3.
`ifdef STR_SUBWORD_EN
    push(EvRe, 32'h100, 32'h0);
    push(EvWe, 32'h100, 32'hAB22_3344);
    push(EvDone, 32'h0, 32'h0);
`else
    push(EvErr, 32'h0, 32'h0);
`endif
    issue(32'h103, 32'h0000_00AB, 2'b10);
    wait_idle();

    // Halfword into the upper lanes, with a two-cycle RAM delay.
    ack_delay = 2;
`ifdef STR_SUBWORD_EN
    push(EvRe, 32'h200, 32'h0);
    push(EvWe, 32'h200, 32'hCAFE_3344);
    push(EvDone, 32'h0, 32'h0);
`else
    push(EvErr, 32'h0, 32'h0);
`endif
    issue(32'h202, 32'h0000_CAFE, 2'b01);
    wait_idle();

    // Byte into lane 0.
    ack_delay = 0;
`ifdef STR_SUBWORD_EN
    push(EvRe, 32'h700, 32'h0);
    push(EvWe, 32'h700, 32'h1122_3355);
    push(EvDone, 32'h0, 32'h0);
`else
    push(EvErr, 32'h0, 32'h0);
`endif
    issue(32'h700, 32'h0000_0055, 2'b10);
    wait_idle();

    // Rejections: misaligned halfword, misaligned word, reserved size.
    push(EvErr, 32'h0, 32'h0);
    issue(32'h201, 32'h1234_5678, 2'b01);
    @(negedge clk);
    check("err_no_busy", 32'(str_busy), 32'd0);
    wait_idle();
    push(EvErr, 32'h0, 32'h0);
    issue(32'h102, 32'h1234_5678, 2'b00);
    wait_idle();
    push(EvErr, 32'h0, 32'h0);
    issue(32'h600, 32'h1234_5678, 2'b11);
    wait_idle();

    // Timeout: ram_ack never comes, strobe lasts exactly 15 cycles.
    ack_delay = -1;
    push(EvWe, 32'h300, 32'h0BAD_F00D);
    push(EvErr, 32'h0, 32'h0);
    issue(32'h300, 32'h0BAD_F00D, 2'b00);
    cnt = 0;
    @(negedge clk);
    while (ram_we && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_we_cycles", 32'(cnt), 32'd15);
    wait_idle();

    // Reset in WR: strobe drops without a clock edge; a second request is ignored.
    push(EvWe, 32'h400, 32'h4444_4444);
    issue(32'h400, 32'h4444_4444, 2'b00);
    @(negedge clk);
    str_addr = 32'h500;
    str_data = 32'h5555_5555;
    str_req  = 1'b1;
    repeat (2) @(negedge clk);
    str_req = 1'b0;
    check("busy_req_ignored_addr", ram_addr, 32'h400);
    check("busy_req_ignored_data", ram_wdata, 32'h4444_4444);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(ram_we), 32'd0);
    check("async_rst_busy", 32'(str_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    repeat (20) @(negedge clk);

    // Controller still works after the abandoned store.
    push(EvWe, 32'h800, 32'h8888_0001);
    push(EvDone, 32'h0, 32'h0);
    issue(32'h800, 32'h8888_0001, 2'b00);
    wait_idle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
